// File: rtl/exec_commit.sv
// Execute-stage sequencer and commit stage wrapped around the ALU.
// Accepts one decoded instruction, enables the ALU until it completes (or a
// wait budget expires), then presents one writeback / PC-update record.
module exec_commit #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned PC_W    = 32
) (
    input  logic            clk,
    input  logic            rstn,           // active-high asynchronous reset
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [PC_W-1:0] issue_pc,
    input  logic [PC_W-1:0] issue_imm,
    input  logic [PC_W-1:0] issue_rs1,
    input  logic [4:0]      issue_rd_idx,
    input  logic [2:0]      issue_kind,
    output logic            alu_enabled,
    input  logic            alu_completed,
    input  logic [PC_W-1:0] alu_rd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_we,
    output logic [4:0]      wb_idx,
    output logic [PC_W-1:0] wb_data,
    output logic [PC_W-1:0] pc_next,
    output logic            redirect,
    output logic            err
);

    typedef enum logic [1:0] {StIdle, StExec, StCommit} state_t;

    localparam int unsigned   CntW    = 16;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [2:0] KindAlu    = 3'd0;
    localparam logic [2:0] KindBranch = 3'd1;
    localparam logic [2:0] KindJal    = 3'd2;
    localparam logic [2:0] KindJalr   = 3'd3;
    localparam logic [2:0] KindNoWr   = 3'd4;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, imm_q, rs1_q;
    logic [4:0]      rd_idx_q;
    logic [2:0]      kind_q;
    logic [CntW-1:0] cnt_q;

    logic            accept, complete, expire, handshake;

    // Record datapath values
    logic [PC_W-1:0] pc_inc, imm_sh, br_tgt, jalr_sum, jalr_tgt;
    logic            rec_we, rec_redir, rec_err;
    logic [PC_W-1:0] rec_data, rec_pc;

    // Registered record outputs
    logic            we_q, redir_q, err_q;
    logic [4:0]      idx_q;
    logic [PC_W-1:0] data_q, pcn_q;

    // Control outputs decode straight from the state register, so issue_ready
    // never depends combinationally on issue_valid.
    assign issue_ready = (state_q == StIdle);
    assign alu_enabled = (state_q == StExec);
    assign wb_valid    = (state_q == StCommit);
    assign handshake   = (state_q == StCommit) && wb_ready;

    assign wb_we    = we_q;
    assign wb_idx   = idx_q;
    assign wb_data  = data_q;
    assign pc_next  = pcn_q;
    assign redirect = redir_q;
    assign err      = err_q;

    // Immediates are byte offsets; PC counts words, hence the arithmetic >>2.
    assign pc_inc   = pc_q + PC_W'(1);
    assign imm_sh   = {{2{imm_q[PC_W-1]}}, imm_q[PC_W-1:2]};
    assign br_tgt   = pc_q + imm_sh;
    assign jalr_sum = rs1_q + imm_q;
    // Clearing bit 0 before a logical >>2 is the same as dropping bits [1:0].
    assign jalr_tgt = {2'b00, jalr_sum[PC_W-1:2]};

    // State register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completion takes priority over the timeout
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        expire   = 1'b0;
        case (state_q)
            StIdle: begin
                if (issue_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (alu_completed) begin
                    complete = 1'b1;
                    state_d  = StCommit;
                end else if (cnt_q == CntLast) begin
                    expire  = 1'b1;
                    state_d = StCommit;
                end
            end
            StCommit: begin
                if (wb_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Commit record computed from the latched instruction and the live ALU result
    always_comb begin
        rec_we    = 1'b0;
        rec_data  = '0;
        rec_pc    = pc_inc;
        rec_redir = 1'b0;
        rec_err   = 1'b0;
        case (kind_q)
            KindAlu: begin
                rec_we   = (rd_idx_q != 5'd0);
                rec_data = rec_we ? alu_rd : '0;
            end
            KindBranch: begin
                rec_redir = alu_rd[0];
                rec_pc    = alu_rd[0] ? br_tgt : pc_inc;
            end
            KindJal: begin
                rec_we    = (rd_idx_q != 5'd0);
                rec_data  = rec_we ? alu_rd : '0;
                rec_pc    = br_tgt;
                rec_redir = 1'b1;
            end
            KindJalr: begin
                rec_we    = (rd_idx_q != 5'd0);
                rec_data  = rec_we ? alu_rd : '0;
                rec_pc    = jalr_tgt;
                rec_redir = 1'b1;
            end
            KindNoWr: begin
                rec_we = 1'b0;
            end
            default: begin
                rec_err = 1'b1;
            end
        endcase
    end

    // Instruction latch and EXEC wait counter
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            pc_q     <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rd_idx_q <= '0;
            kind_q   <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            pc_q     <= issue_pc;
            imm_q    <= issue_imm;
            rs1_q    <= issue_rs1;
            rd_idx_q <= issue_rd_idx;
            kind_q   <= issue_kind;
            cnt_q    <= '0;
        end else if (state_q == StExec) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Record registers: loaded on leaving EXEC, held through COMMIT
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            pcn_q   <= '0;
            redir_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (complete) begin
            we_q    <= rec_we;
            idx_q   <= rd_idx_q;
            data_q  <= rec_data;
            pcn_q   <= rec_pc;
            redir_q <= rec_redir;
            err_q   <= rec_err;
        end else if (expire) begin
            we_q    <= 1'b0;
            idx_q   <= rd_idx_q;
            data_q  <= '0;
            pcn_q   <= pc_inc;
            redir_q <= 1'b0;
            err_q   <= 1'b1;
        end else if (handshake) begin
            err_q <= 1'b0;
        end
    end

endmodule

// File: doc/exec_commit.md
Name: exec_commit

Overview:
- Execute-stage sequencer and commit stage placed directly around the ALU.
- Accepts one decoded instruction from issue and pulses the ALU enable.
- Waits for ALU completion, then resolves branch and jump targets and presents one register-writeback/PC-update record to the writeback port.
- One instruction in flight at a time; PC is a word index, so sequential next PC is pc+1.

Parameters:
TIMEOUT, 64, maximum cycles spent in EXEC waiting for alu_completed before forced error commit (legal range 2..65535).
PC_W, 32, width of PC and all datapath values.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset: asynchronous, active-high (1 = in reset), despite the suffix.
issue_valid  in  1  upstream has an instruction.
issue_ready  out  1  block can accept an instruction.
issue_pc  in  PC_W  word-indexed PC of the instruction.
issue_imm  in  PC_W  sign-extended byte immediate.
issue_rs1  in  PC_W  rs1 operand value (used for jalr target).
issue_rd_idx  in  5  destination register index.
issue_kind  in  3  0=ALU-write, 1=branch, 2=jal, 3=jalr, 4=no-write; 5..7 illegal.
alu_enabled  out  1  enable to ALU.
alu_completed  in  1  ALU result valid this cycle.
alu_rd  in  PC_W  ALU result (branch: bit0 = taken; jal/jalr: link value).
wb_valid  out  1  commit record valid.
wb_ready  in  1  consumer accepts record.
wb_we  out  1  register-file write enable.
wb_idx  out  5  register-file write index.
wb_data  out  PC_W  register-file write data.
pc_next  out  PC_W  next word PC.
redirect  out  1  pc_next is not pc+1 because of control flow.
err  out  1  record is an error commit (timeout or illegal kind).

Behaviour:
- States: IDLE, EXEC, COMMIT. Reset enters IDLE.
- Reset values: issue_ready=1; all other outputs 0, including pc_next, wb_data and counters.
- IDLE:
  - issue_ready=1.
  - On issue_valid: latch pc, imm, rs1, rd_idx and kind; clear the wait counter; go to EXEC.
  - No combinational path from issue_valid to issue_ready.
- EXEC:
  - issue_ready=0 and alu_enabled=1, registered, so it rises the cycle after acceptance.
  - Counter increments each EXEC cycle.
  - alu_completed=1: capture alu_rd, compute the record, go to COMMIT. alu_enabled drops in the next cycle.
  - Counter==TIMEOUT-1 with no completion: go to COMMIT as an error record with wb_we=0, redirect=0, err=1, pc_next=pc+1.
  - Completion in the same cycle as the timeout: completion wins.
- Record computation (all arithmetic mod 2^PC_W):
  - kind0: wb_we=(rd_idx!=0), wb_data=alu_rd, pc_next=pc+1, redirect=0.
  - kind1: wb_we=0, taken=alu_rd[0]. pc_next = taken ? pc+(imm>>>2, arithmetic) : pc+1. redirect=taken.
  - kind2 (jal): wb_we=(rd_idx!=0), wb_data=alu_rd, pc_next=pc+(imm>>>2), redirect=1.
  - kind3 (jalr): wb_we=(rd_idx!=0), wb_data=alu_rd, pc_next=((rs1+imm)&~1)>>2 (logical), redirect=1.
  - kind4: wb_we=0, pc_next=pc+1, redirect=0.
  - kinds 5..7: as kind4, plus err=1.
  - wb_idx always equals the latched rd_idx. wb_data=0 whenever wb_we=0.
- COMMIT:
  - wb_valid=1. All record outputs are held stable until wb_valid&&wb_ready.
  - On handshake, go to IDLE the next cycle; wb_valid=0 and err=0 then.
  - Record outputs other than wb_valid may keep their last value in IDLE/EXEC.
  - issue_ready=0 throughout.
- alu_completed outside EXEC is ignored.
- Minimum occupancy: accept at N, EXEC at N+1 with completion, COMMIT at N+2 with wb_ready, IDLE at N+3.
- Reset asserted in any state:
  - Immediate return to IDLE; in-flight instruction discarded.
  - No wb_valid pulse; outputs return to reset values asynchronously.

Test Plan:
- kind0, rd_idx=3, alu_rd=5, completion on first EXEC cycle -> wb_valid at cycle N+2 with we=1, idx=3, data=5, pc_next=pc+1, redirect=0.
- kind0, rd_idx=0, alu_rd=0xDEADBEEF -> wb_we=0, wb_data=0, err=0.
- Branch pc=0x10, imm=-8, alu_rd=1 -> pc_next=0x0E, redirect=1. Same with alu_rd=0 -> pc_next=0x11, redirect=0.
- jalr rs1=0x103, imm=4, rd_idx=1, alu_rd=pc+1 -> pc_next=0x41, wb_we=1.
- TIMEOUT=4, alu_completed held 0 -> COMMIT after 4 EXEC cycles with err=1, wb_we=0. Also: completion exactly on the 4th cycle -> normal record, err=0.
- wb_ready low for 5 cycles -> record stable and issue_ready=0 throughout; rstn asserted mid-EXEC -> IDLE, issue_ready=1, no wb_valid.
